// File: rtl/text_stream_gen_pkg.sv
// Shared types and LFSR step for the string-matcher stimulus generator.
package text_stream_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_PAT  = 4'd1,
    ST_TXT  = 4'd2,
    ST_DONE = 4'd3
  } state_e;

  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

  // Galois, right-shifting step.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/text_stream_gen_lfsr8.sv
// 8-bit Galois LFSR with seed load and step enable; an all-zero seed would lock up, so it is replaced.
module lfsr8
  import text_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)
      lfsr_d = (seed_i == 8'h00) ? LFSR_ZERO_SEED : seed_i;
    else if (en_i)
      lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_ZERO_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/text_stream_gen.sv
// Generates a pattern and a text containing it, streamed over a valid/ready byte channel.
//   state   | meaning
//   IDLE(0) | waiting for a start edge
//   PAT(1)  | streaming pattern bytes, storing each one
//   TXT(2)  | streaming text bytes, pattern replayed inside the window
//   DONE(3) | one-cycle done pulse
module text_stream_gen
  import text_stream_pkg::*;
#(
  parameter int TEXT_LEN = 16,
  parameter int PAT_LEN  = 4,
  parameter int PAT_POS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inicio,
  input  logic [7:0] sw_bit_inicial,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       data_is_pat,
  output logic       pat_last,
  output logic       text_last,
  output logic       busy,
  output logic       done,
  output logic [3:0] actual_state
);

  localparam int CW = $clog2(TEXT_LEN + 1);
  localparam int PW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  if (PAT_POS + PAT_LEN > TEXT_LEN) begin : g_bad_window
    $error("text_stream_gen: PAT_POS+PAT_LEN must not exceed TEXT_LEN");
  end
  if (TEXT_LEN < 2 || TEXT_LEN > 255 || PAT_LEN < 1 || PAT_LEN > 8) begin : g_bad_len
    $error("text_stream_gen: TEXT_LEN or PAT_LEN out of range");
  end

  state_e          state_q, state_d;
  logic            btn_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            is_pat_q, is_pat_d;
  logic            plast_q, plast_d;
  logic            tlast_q, tlast_d;
  logic [7:0]      pat_mem_q [PAT_LEN];

  logic            lfsr_load, lfsr_step;
  logic [7:0]      lfsr_q, lfsr_stepped;
  logic            start_edge, xfer;
  logic            pres_pat, pres_txt, pat_we;
  logic [CW-1:0]   txt_idx;
  logic [CW:0]     txt_off;
  logic            in_win;
  logic [PW-1:0]   win_idx;
  logic [7:0]      txt_byte;

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load),
    .seed_i (sw_bit_inicial),
    .en_i   (lfsr_step),
    .q_o    (lfsr_q)
  );

  assign lfsr_stepped = lfsr_next(lfsr_q);
  assign start_edge   = btn_inicio & ~btn_q;
  assign xfer         = valid_q & data_ready;

  // Text byte 0 is presented on the cycle that leaves PAT, when cnt_q still counts pattern bytes.
  assign txt_idx  = (state_q == ST_PAT) ? '0 : cnt_q;
  assign txt_off  = {1'b0, txt_idx} - (CW+1)'(PAT_POS);
  assign in_win   = ~txt_off[CW] && (txt_off < (CW+1)'(PAT_LEN));
  assign win_idx  = PW'(txt_off);
  assign txt_byte = in_win ? pat_mem_q[win_idx] : lfsr_stepped;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    is_pat_d  = is_pat_q;
    plast_d   = plast_q;
    tlast_d   = tlast_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    pat_we    = 1'b0;
    pres_pat  = 1'b0;
    pres_txt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          lfsr_load = 1'b1;
          cnt_d     = '0;
          state_d   = ST_PAT;
        end
      end
      ST_PAT: begin
        if (xfer && plast_q) begin
          state_d  = ST_TXT;
          pres_txt = 1'b1;
        end else if (!valid_q || xfer) begin
          pres_pat = 1'b1;
        end
      end
      ST_TXT: begin
        if (xfer) begin
          if (tlast_q) begin
            state_d  = ST_DONE;
            valid_d  = 1'b0;
            is_pat_d = 1'b0;
            plast_d  = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            pres_txt = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (pres_pat) begin
      data_d    = lfsr_stepped;
      lfsr_step = 1'b1;
      pat_we    = 1'b1;
      valid_d   = 1'b1;
      is_pat_d  = 1'b1;
      plast_d   = (cnt_q == CW'(PAT_LEN - 1));
      tlast_d   = 1'b0;
      cnt_d     = cnt_q + 1'b1;
    end

    if (pres_txt) begin
      data_d    = txt_byte;
      lfsr_step = ~in_win;
      valid_d   = 1'b1;
      is_pat_d  = 1'b0;
      plast_d   = 1'b0;
      tlast_d   = (txt_idx == CW'(TEXT_LEN - 1));
      cnt_d     = txt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      btn_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      is_pat_q <= 1'b0;
      plast_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_inicio;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      is_pat_q <= is_pat_d;
      plast_q  <= plast_d;
      tlast_q  <= tlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pat_we) pat_mem_q[PW'(cnt_q)] <= lfsr_stepped;
  end

  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign data_is_pat  = is_pat_q;
  assign pat_last     = plast_q;
  assign text_last    = tlast_q;
  assign busy         = (state_q == ST_PAT) || (state_q == ST_TXT);
  assign done         = (state_q == ST_DONE);
  assign actual_state = state_q;

endmodule

// File: tb/tb_text_stream_gen.sv
// Directed bench for text_stream_gen: default instance plus a TEXT_LEN=PAT_LEN=4, PAT_POS=0 instance.
module tb_text_stream_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inicio;
  logic [7:0] sw_bit_inicial;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid, data_is_pat, pat_last, text_last, busy, done;
  logic [3:0] actual_state;

  logic       btn6, ready6;
  logic [7:0] sw6, out6;
  logic       valid6, is_pat6, plast6, tlast6, busy6, done6;
  logic [3:0] state6;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  text_stream_gen dut (
    .clk(clk), .rst(rst), .btn_inicio(btn_inicio), .sw_bit_inicial(sw_bit_inicial),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .data_is_pat(data_is_pat), .pat_last(pat_last), .text_last(text_last),
    .busy(busy), .done(done), .actual_state(actual_state)
  );

  text_stream_gen #(.TEXT_LEN(4), .PAT_LEN(4), .PAT_POS(0)) dut6 (
    .clk(clk), .rst(rst), .btn_inicio(btn6), .sw_bit_inicial(sw6),
    .data_out(out6), .data_valid(valid6), .data_ready(ready6),
    .data_is_pat(is_pat6), .pat_last(plast6), .text_last(tlast6),
    .busy(busy6), .done(done6), .actual_state(state6)
  );

  // Seed 01: pattern B8 5C 2E 17, then text with the pattern at index 2.
  logic [7:0] exp_main [20] = '{8'hB8, 8'h5C, 8'h2E, 8'h17,
                                8'hB3, 8'hE1, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hC8, 8'h64,
                                8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE, 8'h57, 8'h93};
  logic [7:0] exp_short [8] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB8, 8'h5C, 8'h2E, 8'h17};

  logic [7:0] cap_data [64];
  logic [2:0] cap_flags [64];
  int         cap_cyc [64];
  logic [3:0] trace [16];
  int n_cap, n_done, done_cyc, first_valid_cyc, stall_err, n_trace, n_stall;
  logic busy_at1;

  task automatic run_stream(input logic [7:0] seed, input int ncyc, input bit stalls, input bit held);
    int stall_left;
    logic pv, pr;
    logic [7:0] pd;
    logic [2:0] pf;
    btn_inicio = 1'b0;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cap = 0; n_done = 0; done_cyc = -1; first_valid_cyc = -1;
    stall_err = 0; n_stall = 0; busy_at1 = 1'b0;
    stall_left = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00; pf = 3'b000;
    sw_bit_inicial = seed;
    btn_inicio = 1'b1;
    trace[0] = actual_state;
    n_trace = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (held) btn_inicio = (c < 50) && !(c >= 8 && c < 10);
      else      btn_inicio = 1'b0;
      if (stalls) begin
        data_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (!data_ready) n_stall++;
      end else begin
        data_ready = 1'b1;
      end
      if (actual_state != trace[n_trace-1] && n_trace < 16) begin
        trace[n_trace] = actual_state;
        n_trace++;
      end
      if (c == 1) busy_at1 = busy;
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (pv && !pr) begin
        if (!data_valid || data_out !== pd || {data_is_pat, pat_last, text_last} !== pf)
          stall_err++;
      end
      if (data_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (data_valid && data_ready && n_cap < 64) begin
        cap_data[n_cap]  = data_out;
        cap_flags[n_cap] = {data_is_pat, pat_last, text_last};
        cap_cyc[n_cap]   = c;
        n_cap++;
        if (stalls) stall_left = $urandom_range(0, 5);
      end
      pv = data_valid; pr = data_ready; pd = data_out;
      pf = {data_is_pat, pat_last, text_last};
    end
    btn_inicio = 1'b0;
    data_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({data_out, data_valid, data_is_pat, pat_last, text_last, busy, done, actual_state} !== 18'h0)
      $display("FAIL reset_outputs: got data=%h valid=%b busy=%b done=%b state=%0d, required all 0",
               data_out, data_valid, busy, done, actual_state);
    else pass_cnt++;
    total_cnt++;
    if ({out6, valid6, is_pat6, plast6, tlast6, busy6, done6, state6} !== 18'h0)
      $display("FAIL reset_outputs6: got data=%h valid=%b state=%0d, required all 0", out6, valid6, state6);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_tr [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [2:0] ef;
    run_stream(8'h01, 30, 1'b0, 1'b0);
    total_cnt++;
    if (n_cap != 20) $display("FAIL basic_count: got %0d bytes, required 20", n_cap);
    else pass_cnt++;
    for (int i = 0; i < 20 && i < n_cap; i++) begin
      ef = {(i < 4) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, (i == 19) ? 1'b1 : 1'b0};
      total_cnt++;
      if (cap_data[i] !== exp_main[i] || cap_flags[i] !== ef)
        $display("FAIL basic_byte[%0d]: got %h flags %b, required %h flags %b",
                 i, cap_data[i], cap_flags[i], exp_main[i], ef);
      else pass_cnt++;
    end
    total_cnt++;
    if (first_valid_cyc != 2) $display("FAIL basic_first_latency: got cycle %0d, required 2", first_valid_cyc);
    else pass_cnt++;
    total_cnt++;
    if (busy_at1 !== 1'b1) $display("FAIL basic_busy: got %b in PAT, required 1", busy_at1);
    else pass_cnt++;
    total_cnt++;
    if (n_cap < 20 || cap_cyc[19] != 21)
      $display("FAIL basic_last_latency: got cycle %0d, required 21", (n_cap >= 20) ? cap_cyc[19] : -1);
    else pass_cnt++;
    total_cnt++;
    if (n_done != 1 || done_cyc != 22)
      $display("FAIL basic_done: got %0d pulses at cycle %0d, required 1 at 22", n_done, done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (n_trace != 5 || trace[0] !== exp_tr[0] || trace[1] !== exp_tr[1] || trace[2] !== exp_tr[2] ||
        trace[3] !== exp_tr[3] || trace[4] !== exp_tr[4])
      $display("FAIL basic_state_seq: got %0d states %0d,%0d,%0d,%0d,%0d, required 0,1,2,3,0",
               n_trace, trace[0], trace[1], trace[2], trace[3], trace[4]);
    else pass_cnt++;
  endtask

  task automatic test_zero_seed();
    int bad = 0;
    run_stream(8'h00, 30, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      if (i >= n_cap || cap_data[i] !== exp_main[i]) bad++;
    total_cnt++;
    if (n_cap != 20 || bad != 0)
      $display("FAIL zero_seed_stream: got %0d bytes with %0d wrong, required 20 with 0 wrong", n_cap, bad);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int bad = 0;
    run_stream(8'h01, 200, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      if (i >= n_cap || cap_data[i] !== exp_main[i] || cap_flags[i][0] !== (i == 19)) bad++;
    total_cnt++;
    if (n_cap != 20 || bad != 0)
      $display("FAIL stall_stream: got %0d bytes with %0d wrong, required 20 with 0 wrong", n_cap, bad);
    else pass_cnt++;
    total_cnt++;
    if (stall_err != 0) $display("FAIL stall_stable: got %0d unstable stall cycles, required 0", stall_err);
    else pass_cnt++;
    total_cnt++;
    if (n_done != 1) $display("FAIL stall_done: got %0d done pulses, required 1", n_done);
    else pass_cnt++;
  endtask

  task automatic test_held_button();
    int bad = 0;
    run_stream(8'h01, 80, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      if (i >= n_cap || cap_data[i] !== exp_main[i]) bad++;
    total_cnt++;
    if (n_cap != 20 || bad != 0)
      $display("FAIL held_single_run: got %0d bytes with %0d wrong, required 20 with 0 wrong", n_cap, bad);
    else pass_cnt++;
    total_cnt++;
    if (n_done != 1) $display("FAIL held_done: got %0d done pulses, required 1", n_done);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int got = 0;
    int bad = 0;
    int leak = 0;
    btn_inicio = 1'b0;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sw_bit_inicial = 8'h01;
    btn_inicio = 1'b1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(posedge clk);
      #1;
      btn_inicio = 1'b0;
      if (data_valid && data_ready) got++;
    end
    total_cnt++;
    if (got != 8) $display("FAIL mid_reset_reach: got %0d bytes, required 8 before reset", got);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (actual_state !== 4'd2) $display("FAIL mid_reset_in_txt: got state %0d, required 2", actual_state);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || actual_state !== 4'd0)
      $display("FAIL mid_reset_abort: got valid=%b busy=%b state=%0d, required 0 0 0",
               data_valid, busy, actual_state);
    else pass_cnt++;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (data_valid) leak++;
    end
    total_cnt++;
    if (leak != 0) $display("FAIL mid_reset_quiet: got %0d valid cycles after reset, required 0", leak);
    else pass_cnt++;
    run_stream(8'h01, 30, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      if (i >= n_cap || cap_data[i] !== exp_main[i]) bad++;
    total_cnt++;
    if (n_cap != 20 || bad != 0)
      $display("FAIL mid_reset_rerun: got %0d bytes with %0d wrong, required 20 with 0 wrong", n_cap, bad);
    else pass_cnt++;
  endtask

  task automatic test_short_params();
    int n = 0;
    int dcyc = -1;
    int lastc = -1;
    logic [7:0] d [8];
    logic [2:0] f [8];
    logic [2:0] ef;
    btn6 = 1'b0;
    ready6 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sw6 = 8'h01;
    btn6 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      btn6 = 1'b0;
      if (done6) dcyc = c;
      if (valid6 && ready6 && n < 8) begin
        d[n] = out6;
        f[n] = {is_pat6, plast6, tlast6};
        lastc = c;
        n++;
      end
    end
    total_cnt++;
    if (n != 8) $display("FAIL short_count: got %0d bytes, required 8", n);
    else pass_cnt++;
    for (int i = 0; i < 8 && i < n; i++) begin
      ef = {(i < 4) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0};
      total_cnt++;
      if (d[i] !== exp_short[i] || f[i] !== ef)
        $display("FAIL short_byte[%0d]: got %h flags %b, required %h flags %b", i, d[i], f[i], exp_short[i], ef);
      else pass_cnt++;
    end
    total_cnt++;
    if (lastc != 9 || dcyc != 10)
      $display("FAIL short_timing: got last at %0d done at %0d, required 9 and 10", lastc, dcyc);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    btn_inicio = 1'b0;
    sw_bit_inicial = 8'h00;
    data_ready = 1'b1;
    btn6 = 1'b0;
    sw6 = 8'h00;
    ready6 = 1'b1;
    test_reset();
    test_basic();
    test_zero_seed();
    test_stall();
    test_held_button();
    test_mid_reset();
    test_short_params();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
